fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC, issues in-order requests to a variable-latency instruction memory, and buffers returned {pc,instr} pairs in a small queue.
- Presents one 64-bit {pc[31:0],instr[31:0]} word per cycle to IF/ID; accepts branch/jump redirects from EX and discards stale fetches.

---
 rtl/pipeline_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 51 +++++
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline widths, IF/ID packet type and saturating-add helper
package pipeline_pkg;

  localparam int XLEN    = 32;
  localparam int IF_ID_W = 64;
  localparam logic [IF_ID_W-1:0] NOP_BUBBLE = 64'h0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush; caller never pushes into a full FIFO
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // DEPTH need not be a power of two (in-flight PC FIFO), so wrap explicitly
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop   = pop && (count != '0);
  assign do_push  = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage feeding IF/ID; FETCH_PERF_EN adds perf counters
module fetch_unit
  import pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              DEPTH     = 4,
  parameter int              MAX_OUTST = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_resp_valid,
  input  logic [XLEN-1:0]    imem_resp_data,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  input  logic               id_ready,
  output logic               fetch_valid,
  output logic [IF_ID_W-1:0] fetch_out
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_discarded,
  output logic [31:0]        perf_starve
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OST_W = $clog2(MAX_OUTST + 1);

  logic [XLEN-1:0]  pc_q, redirect_target, resp_pc;
  logic [CNT_W-1:0] outst_q, outst_next, discard_q, q_count;
  logic [OST_W-1:0] pcf_count;
  logic [CNT_W:0]   credit_used;
  logic             req_hs, resp_keep, resp_drop, pop;
  fetch_pkt_t       head_pkt, push_pkt;

  assign redirect_target = redirect_pc & ~32'h3;
  assign credit_used     = {1'b0, q_count} + {1'b0, outst_q};

  // Queue slots are reserved at issue time, so a response can always be pushed
  assign imem_req_valid = !reset && !redirect_valid
                       && (credit_used < (CNT_W + 1)'(DEPTH))
                       && (outst_q < CNT_W'(MAX_OUTST));
  assign imem_req_addr  = pc_q;
  assign req_hs         = imem_req_valid && imem_req_ready;

  assign resp_keep  = imem_resp_valid && !redirect_valid && (discard_q == '0);
  assign resp_drop  = imem_resp_valid && !resp_keep;
  assign outst_next = outst_q + CNT_W'(req_hs) - CNT_W'(imem_resp_valid);

  assign fetch_valid = (q_count != '0);
  assign fetch_out   = fetch_valid ? head_pkt : NOP_BUBBLE;
  assign pop         = fetch_valid && id_ready && !redirect_valid;
  assign push_pkt    = '{pc: resp_pc, instr: imem_resp_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      outst_q   <= '0;
      discard_q <= '0;
    end else begin
      outst_q <= outst_next;
      if (redirect_valid) begin
        pc_q      <= redirect_target;
        discard_q <= outst_next;
      end else begin
        if (req_hs)    pc_q      <= pc_q + 32'd4;
        if (resp_drop) discard_q <= discard_q - CNT_W'(1);
      end
    end
  end

  // Stale requests need no PC, so the PC FIFO is flushed alongside the queue
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTST)) u_pc_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (req_hs),
    .push_data (pc_q),
    .pop       (resp_keep),
    .pop_data  (resp_pc),
    .count     (pcf_count)
  );

  fetch_fifo #(.WIDTH(IF_ID_W), .DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (resp_keep),
    .push_data (push_pkt),
    .pop       (pop),
    .pop_data  (head_pkt),
    .count     (q_count)
  );

  a_resp_needs_req: assert property (@(posedge clk) disable iff (reset)
    imem_resp_valid |-> (outst_q != '0));
  a_inflight_split: assert property (@(posedge clk) disable iff (reset)
    (CNT_W'(pcf_count) + discard_q) == outst_q);

`ifdef FETCH_PERF_EN
  logic [31:0] disc_inc;
  assign disc_inc = 32'(resp_drop) + (redirect_valid ? 32'(q_count) : 32'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched   <= '0;
      perf_discarded <= '0;
      perf_starve    <= '0;
    end else begin
      perf_fetched   <= sat_add32(perf_fetched, 32'(pop));
      perf_discarded <= sat_add32(perf_discarded, disc_inc);
      perf_starve    <= sat_add32(perf_starve, 32'(id_ready && !fetch_valid));
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized fetch_unit bench against a queue-based reference model
module tb_fetch_unit;

  localparam int DEPTH     = 4;
  localparam int MAX_OUTST = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        fetch_valid;
  logic [63:0] fetch_out;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_discarded, perf_starve;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .id_ready        (id_ready),
    .fetch_valid     (fetch_valid),
    .fetch_out       (fetch_out)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_discarded  (perf_discarded),
    .perf_starve     (perf_starve)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          due;
    bit          stale;
  } req_t;

  req_t        pend[$];
  logic [63:0] mq[$];
  logic [31:0] m_pc;
  int          cyc;
  int          m_fetched, m_discarded, m_starve;
  int          checks, errors;

  int          lat_min, lat_max, p_idr, p_rqr, p_redir;
  bit          force_redir, force_busy;
  logic [31:0] force_pc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    pend.delete();
    mq.delete();
    m_pc = RESET_PC;
    m_fetched = 0;
    m_discarded = 0;
    m_starve = 0;
  endtask

  task automatic step();
    bit          resp, redir, idr, rqr, exp_rv, hs, pop;
    logic [31:0] rpc;
    req_t        r;
    @(negedge clk);
    resp = (pend.size() > 0) && (pend[0].due <= cyc);
    idr  = ($urandom_range(99) < p_idr);
    rqr  = ($urandom_range(99) < p_rqr);
    redir = 1'b0;
    rpc   = $urandom;
    if (force_redir && (!force_busy || (resp && mq.size() > 0 && idr))) begin
      redir = 1'b1;
      rpc = force_pc;
      force_redir = 1'b0;
    end else if ($urandom_range(999) < p_redir) begin
      redir = 1'b1;
    end
    imem_resp_valid = resp;
    imem_resp_data  = resp ? pend[0].data : $urandom;
    id_ready        = idr;
    imem_req_ready  = rqr;
    redirect_valid  = redir;
    redirect_pc     = rpc;
    #1;
    exp_rv = !redir && (mq.size() + pend.size() < DEPTH) && (pend.size() < MAX_OUTST);
    check("req_valid", imem_req_valid, exp_rv);
    if (exp_rv) check("req_addr", imem_req_addr, m_pc);
    check("fetch_valid", fetch_valid, mq.size() != 0);
    check("fetch_out", fetch_out, (mq.size() != 0) ? mq[0] : 64'h0);

    hs  = exp_rv && rqr;
    pop = (mq.size() != 0) && idr && !redir;
    if (idr && mq.size() == 0) m_starve++;
    if (pop) begin
      void'(mq.pop_front());
      m_fetched++;
    end
    if (resp) begin
      r = pend.pop_front();
      if (r.stale || redir) m_discarded++;
      else mq.push_back({r.pc, r.data});
    end
    if (hs) begin
      pend.push_back('{pc: m_pc, data: $urandom, due: cyc + $urandom_range(lat_max, lat_min), stale: 1'b0});
      m_pc = m_pc + 32'd4;
    end
    if (redir) begin
      m_discarded += mq.size();
      mq.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
      m_pc = {rpc[31:2], 2'b00};
    end
    cyc++;
  endtask

  task automatic idle_inputs();
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    imem_req_ready  = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    id_ready        = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, imem_req_valid, 1'b0);
    check({tag, "_fetch_valid"}, fetch_valid, 1'b0);
    check({tag, "_fetch_out"}, fetch_out, 64'h0);
`ifdef FETCH_PERF_EN
    check({tag, "_perf_fetched"}, perf_fetched, 64'h0);
    check({tag, "_perf_discarded"}, perf_discarded, 64'h0);
    check({tag, "_perf_starve"}, perf_starve, 64'h0);
`endif
  endtask

  task automatic check_perf(input string tag);
`ifdef FETCH_PERF_EN
    check({tag, "_perf_fetched"}, perf_fetched, m_fetched);
    check({tag, "_perf_discarded"}, perf_discarded, m_discarded);
    check({tag, "_perf_starve"}, perf_starve, m_starve);
`else
    check({tag, "_model_sane"}, fetch_valid, mq.size() != 0);
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    force_redir = 1'b0;
    force_busy  = 1'b0;
    force_pc    = '0;
    p_redir = 0;
    idle_inputs();
    model_clear();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;

    // streaming with 1-cycle memory
    lat_min = 1; lat_max = 1; p_idr = 100; p_rqr = 100;
    repeat (12) step();

    // ID stall fills the queue, then drains in order
    p_idr = 0;
    repeat (10) step();
    p_idr = 100;
    repeat (8) step();

    // redirect with requests in flight at latency 3
    lat_min = 3; lat_max = 3;
    repeat (8) step();
    force_pc = 32'h100; force_busy = 1'b0; force_redir = 1'b1;
    repeat (12) step();

    // redirect coincident with a response and a pop
    lat_min = 1; lat_max = 1;
    force_pc = 32'h40; force_busy = 1'b1; force_redir = 1'b1;
    repeat (12) step();
    force_redir = 1'b0;

    // unaligned target and address wrap
    force_pc = 32'h203; force_busy = 1'b0; force_redir = 1'b1;
    repeat (4) step();
    force_pc = 32'hFFFF_FFF8; force_redir = 1'b1;
    repeat (6) step();
    check_perf("directed");

    // async reset mid-burst with a partly filled queue
    p_idr = 0;
    repeat (4) step();
    @(negedge clk);
    #2 reset = 1'b1;
    idle_inputs();
    #1;
    check_reset_outputs("midrst");
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    p_idr = 100;
    repeat (8) step();

    // randomized traffic
    for (int blk = 0; blk < 15; blk++) begin
      lat_min = 1;
      lat_max = $urandom_range(6, 1);
      p_idr   = $urandom_range(100, 0);
      p_rqr   = $urandom_range(100, 10);
      p_redir = $urandom_range(80, 0);
      repeat (200) step();
    end
    check_perf("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
